data_memory_arbiter: RTL and testbench
======================================

// Module: data_memory_arbiter
// PURPOSE
//  Shares one read/write port of the 32-bit data memory (TheDataMemory) between two requesters.
//  Requester 0 is the execute stage; requester 1 is a debug/loader master.
//  Round-robin arbitration with burst lock: an owner keeps the port while it holds req,
//  up to MAX_BURST granted beats when the other side is waiting.
//  Sits between execution/debug logic and one data_rdN/data_wrN port pair of the memory.
// PARAMETERS
//  ADDR_W     9   data memory address width (bits)
//  DATA_W     32  data word width (bits)
//  MAX_BURST  4   max consecutive granted beats while the other requester waits (>=1)
// PORTS
//  clock       in   1       system clock, rising edge
//  reset       in   1       asynchronous, active-low reset
//  req0        in   1       requester 0 access request
//  we0         in   1       requester 0 write (1) / read (0)
//  addr0       in   ADDR_W  requester 0 address
//  wdata0      in   DATA_W  requester 0 write data
//  gnt0        out  1       requester 0 beat accepted this cycle
//  rvalid0     out  1       requester 0 read data valid
//  rdata0      out  DATA_W  requester 0 read data
//  req1/we1/addr1/wdata1/gnt1/rvalid1/rdata1  as above, requester 1
//  mem_addr    out  ADDR_W  to memory read and write address
//  mem_wdata   out  DATA_W  to memory write data
//  mem_we      out  1       to memory write enable
//  mem_rdata   in   DATA_W  from memory; synchronous read, valid 1 cycle after address
//  owner       out  2       debug: 00 idle, 01 req0 owns, 10 req1 owns
// BEHAVIOUR
//  Reset (reset==0, async): state IDLE, last_owner=1, beat_cnt=0.
//   rvalid0/1=0; rdata0/1=0.
//   Combinational outputs settle to: gnt0/1=0, mem_we=0, mem_addr=0, mem_wdata=0, owner=00.
//   Reset mid-burst drops the grant immediately; an in-flight read returns no rvalid.
//  States: IDLE, OWN0, OWN1 (registered; owner is the state encoding).
//   Grant is combinational from state: gnt0 = (state==OWN0) & req0; gnt1 likewise.
//   A beat is one cycle with gntN=1.
//  Memory mux: in OWNn, mem_addr/mem_wdata come from requester n; mem_we = wen & gntn.
//   In IDLE, mem_* = 0.
//  IDLE transitions:
//   req0 & !req1 -> OWN0; req1 & !req0 -> OWN1.
//   Both requesting -> OWN of the requester != last_owner.
//   Neither requesting -> stay IDLE.
//   Request-to-first-grant latency from IDLE is 1 cycle.
//  OWNn transitions, evaluated at each edge:
//   !reqn & req_other -> OWN_other (no idle cycle).
//   !reqn & !req_other -> IDLE.
//   reqn & req_other & beat_cnt==MAX_BURST-1 on a granted beat -> OWN_other (forced switch).
//   Otherwise stay.
//  beat_cnt: +1 per granted beat; cleared on any state change. Saturates at MAX_BURST-1
//   while the other requester is idle, so an unopposed owner streams indefinitely.
//  last_owner updates to n on every exit from OWNn.
//  Reads: granted read beat in cycle t -> rvalidn=1 and rdatan=mem_rdata in cycle t+1.
//   Reads are pipelined, one per cycle. rdata holds its last value when rvalid=0.
//  Writes: committed by memory on the edge ending the granted beat; no response pulse.
//  Requester must hold addr/we/wdata stable while req=1 and gnt=0; it may change them
//   after each granted beat.
//  gnt0 & gnt1 are never both 1.
// TESTING
//  1. Assert reset low mid-run with req0 held and a read in flight.
//     -> gnt0/rvalid0 drop same cycle; owner=00.
//  2. req0 only, read addr 5 holding 0xDEADBEEF.
//     -> gnt0 on cycle 2; rvalid0=1, rdata0=0xDEADBEEF on cycle 3.
//  3. req0 and req1 both rise in IDLE after reset -> OWN0 first (last_owner=1).
//     With MAX_BURST=4 both held: 4 gnt0 beats, then 4 gnt1 beats, alternating.
//  4. req1 write 0x12345678 to addr 0x1FF, then req0 read of 0x1FF after switch.
//     -> rdata0=0x12345678.
//  5. OWN0 with only req0 held for 10 cycles -> 10 consecutive gnt0 beats, no forced switch.
//     req1 rises at beat 6 -> switch after 4 further beats at most.
//  6. MAX_BURST=1, both requesting -> gnt0, gnt1 alternate every cycle.
//     Assert gnt0 & gnt1 == 0 throughout all tests.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter
//   Shares one read/write port of the 32-bit data memory between the execute
//   stage (requester 0) and a debug/loader master (requester 1).
//   Round-robin arbitration with burst lock: the owner keeps the port while it
//   holds req, for up to MAX_BURST granted beats once the other side is waiting.
//   An unopposed owner streams indefinitely.
//
// Ports
//   clock, reset             rising-edge clock, async active-low reset
//   reqN/weN/addrN/wdataN    requester N access request (we=1 write, 0 read)
//   gntN                     requester N beat accepted this cycle
//   rvalidN/rdataN           read response, one cycle after the granted beat
//   mem_addr/mem_wdata/mem_we  to the memory port
//   mem_rdata                from the memory, synchronous read (1-cycle latency)
//   owner                    debug: 00 idle, 01 req0 owns, 10 req1 owns
module data_memory_arbiter #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    // State encoding doubles as the debug owner field.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t            state, state_n;
    logic              last_owner;
    logic [CNT_W-1:0]  beat_cnt;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    // Next-state and output decode
    always_comb begin
        state_n   = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        case (state)
            IDLE: begin
                if (req0 && req1)
                    state_n = last_owner ? OWN0 : OWN1;
                else if (req0)
                    state_n = OWN0;
                else if (req1)
                    state_n = OWN1;
            end
            OWN0: begin
                gnt0      = req0;
                mem_addr  = addr0;
                mem_wdata = wdata0;
                mem_we    = we0 & req0;
                if (!req0)
                    state_n = req1 ? OWN1 : IDLE;
                else if (req1 && beat_cnt == CNT_MAX)
                    state_n = OWN1;   // forced switch, req0 held so this beat was granted
            end
            OWN1: begin
                gnt1      = req1;
                mem_addr  = addr1;
                mem_wdata = wdata1;
                mem_we    = we1 & req1;
                if (!req1)
                    state_n = req0 ? OWN0 : IDLE;
                else if (req0 && beat_cnt == CNT_MAX)
                    state_n = OWN0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            beat_cnt   <= '0;
        end else begin
            state <= state_n;
            if (state == OWN0 && state_n != OWN0)
                last_owner <= 1'b0;
            else if (state == OWN1 && state_n != OWN1)
                last_owner <= 1'b1;
            // Saturating at CNT_MAX lets an unopposed owner stream; once the
            // other side requests, the saturated count forces the switch.
            if (state_n != state)
                beat_cnt <= '0;
            else if ((gnt0 || gnt1) && beat_cnt != CNT_MAX)
                beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end

    // Read response: memory data arrives one cycle after the granted beat and
    // is passed straight through; the held copy covers cycles with no rvalid.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
            if (rvalid0) rdata0_q <= mem_rdata;
            if (rvalid1) rdata1_q <= mem_rdata;
        end
    end

    assign rdata0 = rvalid0 ? mem_rdata : rdata0_q;
    assign rdata1 = rvalid1 ? mem_rdata : rdata1_q;
    assign owner  = state;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter: a MAX_BURST=4 instance backed by a
// small synchronous memory model, and a MAX_BURST=1 instance for alternation.
module tb_data_memory_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [8:0]  addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [31:0] rdata0, rdata1, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [8:0]  mem_addr;
    logic [1:0]  owner;

    logic        b_req0 = 0, b_req1 = 0;
    logic        b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_mem_we;
    logic [31:0] b_rdata0, b_rdata1, b_mem_wdata;
    logic [8:0]  b_mem_addr;
    logic [1:0]  b_owner;

    logic [31:0] mem [0:511];
    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    data_memory_arbiter #(.ADDR_W(9), .DATA_W(32), .MAX_BURST(4)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    data_memory_arbiter #(.ADDR_W(9), .DATA_W(32), .MAX_BURST(1)) dut1 (
        .clock(clock), .reset(reset),
        .req0(b_req0), .we0(1'b0), .addr0(9'd3), .wdata0(32'd0),
        .gnt0(b_gnt0), .rvalid0(b_rvalid0), .rdata0(b_rdata0),
        .req1(b_req1), .we1(1'b0), .addr1(9'd4), .wdata1(32'd0),
        .gnt1(b_gnt1), .rvalid1(b_rvalid1), .rdata1(b_rdata1),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
        .mem_rdata(32'd0), .owner(b_owner)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
        chk("excl", 32'(gnt0 & gnt1), 32'd0);
        chk("excl_b", 32'(b_gnt0 & b_gnt1), 32'd0);
    endtask

    initial begin
        // Reset state
        mid();
        chk("rst_gnt0", 32'(gnt0), 0);
        chk("rst_gnt1", 32'(gnt1), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_rvalid0", 32'(rvalid0), 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        #2 reset = 1'b1;

        // req1 writes 0xDEADBEEF to address 5
        tick(); req1 = 1; we1 = 1; addr1 = 9'd5; wdata1 = 32'hDEADBEEF;
        mid(); chk("w5_idle_gnt1", 32'(gnt1), 0);
        tick();
        mid(); chk("w5_gnt1", 32'(gnt1), 1);
        chk("w5_mem_we", 32'(mem_we), 1);
        chk("w5_mem_addr", 32'(mem_addr), 5);
        chk("w5_mem_wdata", mem_wdata, 32'hDEADBEEF);
        tick(); req1 = 0; we1 = 0;
        mid(); chk("w5_owner", 32'(owner), 32'h2);
        chk("w5_gnt1_off", 32'(gnt1), 0);
        tick();
        mid(); chk("w5_idle", 32'(owner), 0);

        // req0 read of address 5: grant on cycle 2, data on cycle 3
        tick(); req0 = 1; we0 = 0; addr0 = 9'd5;
        mid(); chk("r5_c1_gnt0", 32'(gnt0), 0);
        tick();
        mid(); chk("r5_c2_gnt0", 32'(gnt0), 1);
        chk("r5_c2_addr", 32'(mem_addr), 5);
        chk("r5_c2_we", 32'(mem_we), 0);
        tick(); req0 = 0;
        mid(); chk("r5_c3_rvalid0", 32'(rvalid0), 1);
        chk("r5_c3_rdata0", rdata0, 32'hDEADBEEF);

        // Reset mid-burst with a read in flight
        tick(); req0 = 1; addr0 = 9'd5;
        mid();
        tick();
        mid(); chk("mr_gnt0_pre", 32'(gnt0), 1);
        #1 reset = 1'b0;
        #1;
        chk("mr_gnt0", 32'(gnt0), 0);
        chk("mr_owner", 32'(owner), 0);
        chk("mr_rvalid0", 32'(rvalid0), 0);
        chk("mr_rdata0", rdata0, 0);
        chk("mr_addr", 32'(mem_addr), 0);
        tick(); req0 = 0;
        mid(); chk("mr_rvalid0_next", 32'(rvalid0), 0);
        #2 reset = 1'b1;

        // Both request from IDLE after reset: req0 first, 4-beat alternation
        tick(); req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 9'd1; addr1 = 9'd2;
        mid(); chk("rr_idle_gnt0", 32'(gnt0), 0);
        chk("rr_idle_gnt1", 32'(gnt1), 0);
        for (int i = 0; i < 16; i++) begin
            tick();
            mid();
            chk($sformatf("rr_gnt0_%0d", i), 32'(gnt0), 32'(((i / 4) % 2) == 0));
            chk($sformatf("rr_gnt1_%0d", i), 32'(gnt1), 32'(((i / 4) % 2) == 1));
        end
        tick(); req0 = 0; req1 = 0;
        mid(); chk("rr_end_owner", 32'(owner), 32'h1);
        chk("rr_end_gnt0", 32'(gnt0), 0);
        tick();

        // req1 writes 0x1FF, then req0 reads it after the hand-over
        req1 = 1; we1 = 1; addr1 = 9'h1FF; wdata1 = 32'h12345678;
        req0 = 1; we0 = 0; addr0 = 9'h1FF;
        mid(); chk("wr_idle", 32'(owner), 0);
        tick();
        mid(); chk("wr_gnt1", 32'(gnt1), 1);
        chk("wr_gnt0", 32'(gnt0), 0);
        chk("wr_mem_we", 32'(mem_we), 1);
        chk("wr_mem_addr", 32'(mem_addr), 32'h1FF);
        chk("wr_mem_wdata", mem_wdata, 32'h12345678);
        tick(); req1 = 0; we1 = 0;
        mid(); chk("wr_hand_owner", 32'(owner), 32'h2);
        chk("wr_hand_gnt0", 32'(gnt0), 0);
        tick();
        mid(); chk("rd_gnt0", 32'(gnt0), 1);
        chk("rd_mem_addr", 32'(mem_addr), 32'h1FF);
        chk("rd_mem_we", 32'(mem_we), 0);
        tick(); req0 = 0;
        mid(); chk("rd_rvalid0", 32'(rvalid0), 1);
        chk("rd_rdata0", rdata0, 32'h12345678);
        tick();
        mid(); chk("rd_hold_rvalid0", 32'(rvalid0), 0);
        chk("rd_hold_rdata0", rdata0, 32'h12345678);
        chk("rd_hold_owner", 32'(owner), 0);

        // Unopposed streaming, then req1 arrives with the count saturated
        tick(); req0 = 1; we0 = 0; addr0 = 9'd5;
        mid(); chk("st_idle_gnt0", 32'(gnt0), 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            mid();
            chk($sformatf("st_gnt0_%0d", i), 32'(gnt0), 1);
            chk($sformatf("st_rvalid0_%0d", i), 32'(rvalid0), 32'(i > 0));
            if (i > 0) chk($sformatf("st_rdata0_%0d", i), rdata0, 32'hDEADBEEF);
        end
        tick(); req1 = 1; we1 = 0; addr1 = 9'd5;
        mid(); chk("st_last_gnt0", 32'(gnt0), 1);
        chk("st_last_gnt1", 32'(gnt1), 0);
        tick();
        mid(); chk("st_sw_gnt0", 32'(gnt0), 0);
        chk("st_sw_gnt1", 32'(gnt1), 1);
        chk("st_sw_owner", 32'(owner), 32'h2);
        tick(); req0 = 0; req1 = 0;
        mid();
        tick();
        mid(); chk("st_end_owner", 32'(owner), 0);

        // MAX_BURST=1: strict alternation starting with req0
        tick(); b_req0 = 1; b_req1 = 1;
        mid(); chk("b1_idle_gnt0", 32'(b_gnt0), 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            mid();
            chk($sformatf("b1_gnt0_%0d", i), 32'(b_gnt0), 32'((i % 2) == 0));
            chk($sformatf("b1_gnt1_%0d", i), 32'(b_gnt1), 32'((i % 2) == 1));
        end
        tick(); b_req0 = 0; b_req1 = 0;
        mid();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
